// File: rtl/video_timing_meter.sv
// video_timing_meter: sink-side monitor for a VGA-style stream (hs, vs, de, ce_pix).
// Measures line/frame geometry and sync polarities once per frame, reports them
// with a one-cycle frame_stb, and raises `locked` after STABLE_FRAMES identical
// frames. All counters saturate instead of wrapping and flag the frame as overflowed.
module video_timing_meter #(
    parameter int HW            = 12,
    parameter int VW            = 11,
    parameter int STABLE_FRAMES = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          hs,
    input  logic          vs,
    input  logic          de,
    output logic [HW-1:0] h_total,
    output logic [HW-1:0] h_active,
    output logic [VW-1:0] v_total,
    output logic [VW-1:0] v_active,
    output logic          hs_pol,
    output logic          vs_pol,
    output logic          frame_stb,
    output logic          locked,
    output logic          overflow
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

    // One frame's worth of reported timing; also the unit compared for stability.
    typedef struct packed {
        logic [HW-1:0] h_total;
        logic [HW-1:0] h_active;
        logic [VW-1:0] v_total;
        logic [VW-1:0] v_active;
        logic          hs_pol;
        logic          vs_pol;
    } meas_t;

    // Previous samples for edge detection
    logic hs_q, vs_q;
    logic hs_rise, vs_rise;

    // Horizontal state
    logic [HW-1:0] pix_cnt, hs_hi, hs_lo, de_cnt;
    logic [HW-1:0] line_len, line_act;
    logic          hs_pol_i;

    // Vertical state
    logic [VW-1:0] line_cnt, de_lines, vs_hi, vs_lo;
    logic          ovf_flag;

    // Values as they stand after this ce_pix's hs processing; a coincident
    // hs edge is thereby folded into the frame that is closing.
    logic [HW-1:0] line_len_n, line_act_n;
    logic          hs_pol_n;
    logic [VW-1:0] line_cnt_n, de_lines_n, vs_hi_n, vs_lo_n;
    logic          v_sat, h_sat, pix_sat, ovf_n;
    meas_t         frame_n;

    // Frame close handoff and reporting
    meas_t         snap, cur;
    logic          snap_ovf, close_pend, primed;
    logic [3:0]    stable_cnt, stable_n;

    assign hs_rise = ce_pix & hs & ~hs_q;
    assign vs_rise = ce_pix & vs & ~vs_q;

    // Pixel counter stuck at all-ones: also the loss-of-signal indication.
    assign pix_sat = ce_pix & ~hs_rise & (&pix_cnt);
    assign h_sat   = ce_pix & ~hs_rise &
                     ((hs & (&hs_hi)) | (~hs & (&hs_lo)) | (de & (&de_cnt)));
    assign ovf_n   = ovf_flag | pix_sat | h_sat | v_sat;

    // Line-end latches and per-line vertical accounting for the current ce_pix
    always_comb begin
        line_len_n = line_len;
        line_act_n = line_act;
        hs_pol_n   = hs_pol_i;
        line_cnt_n = line_cnt;
        de_lines_n = de_lines;
        vs_hi_n    = vs_hi;
        vs_lo_n    = vs_lo;
        v_sat      = 1'b0;
        if (hs_rise) begin
            line_len_n = pix_cnt;
            hs_pol_n   = (hs_hi < hs_lo);
            if (&line_cnt) v_sat = 1'b1;
            else           line_cnt_n = line_cnt + VW'(1);
            if (de_cnt != '0) begin
                line_act_n = de_cnt;
                if (&de_lines) v_sat = 1'b1;
                else           de_lines_n = de_lines + VW'(1);
            end
            if (vs) begin
                if (&vs_hi) v_sat = 1'b1;
                else        vs_hi_n = vs_hi + VW'(1);
            end else begin
                if (&vs_lo) v_sat = 1'b1;
                else        vs_lo_n = vs_lo + VW'(1);
            end
        end
    end

    // Assemble the frame record that a vs edge in this cycle would capture
    always_comb begin
        frame_n          = '0;
        frame_n.h_total  = line_len_n;
        frame_n.h_active = line_act_n;
        frame_n.v_total  = line_cnt_n;
        frame_n.v_active = de_lines_n;
        frame_n.hs_pol   = hs_pol_n;
        frame_n.vs_pol   = (vs_hi_n < vs_lo_n);
    end

    // Stability count the upcoming frame close would produce
    always_comb begin
        stable_n = 4'd0;
        if (primed && (snap == cur) && !snap_ovf)
            stable_n = (stable_cnt == STABLE_N) ? stable_cnt : stable_cnt + 4'd1;
    end

    // Horizontal counters and sync sampling, all qualified by ce_pix
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            pix_cnt  <= '0;
            hs_hi    <= '0;
            hs_lo    <= '0;
            de_cnt   <= '0;
            line_len <= '0;
            line_act <= '0;
            hs_pol_i <= 1'b1;
        end else if (ce_pix) begin
            hs_q     <= hs;
            vs_q     <= vs;
            line_len <= line_len_n;
            line_act <= line_act_n;
            hs_pol_i <= hs_pol_n;
            if (hs_rise) begin
                pix_cnt <= HW'(1);
                hs_hi   <= HW'(1);
                hs_lo   <= '0;
                de_cnt  <= HW'(de);
            end else begin
                if (!(&pix_cnt)) pix_cnt <= pix_cnt + HW'(1);
                if (hs) begin
                    if (!(&hs_hi)) hs_hi <= hs_hi + HW'(1);
                end else begin
                    if (!(&hs_lo)) hs_lo <= hs_lo + HW'(1);
                end
                if (de && !(&de_cnt)) de_cnt <= de_cnt + HW'(1);
            end
        end
    end

    // Vertical counters; a vs edge snapshots the frame and restarts them
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            line_cnt <= '0;
            de_lines <= '0;
            vs_hi    <= '0;
            vs_lo    <= '0;
            ovf_flag <= 1'b0;
            snap     <= '0;
            snap_ovf <= 1'b0;
        end else if (ce_pix) begin
            if (vs_rise) begin
                line_cnt <= '0;
                de_lines <= '0;
                vs_hi    <= '0;
                vs_lo    <= '0;
                ovf_flag <= 1'b0;
                snap     <= frame_n;
                snap_ovf <= ovf_n;
            end else begin
                line_cnt <= line_cnt_n;
                de_lines <= de_lines_n;
                vs_hi    <= vs_hi_n;
                vs_lo    <= vs_lo_n;
                ovf_flag <= ovf_n;
            end
        end
    end

    // Report one clk_sys after the vs edge, independent of ce_pix
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) close_pend <= 1'b0;
        else       close_pend <= vs_rise;
    end

    // Outputs, stability tracking and lock; loss of hs overrides the lock
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cur        <= '0;
            cur.hs_pol <= 1'b1;
            cur.vs_pol <= 1'b1;
            frame_stb  <= 1'b0;
            overflow   <= 1'b0;
            locked     <= 1'b0;
            stable_cnt <= 4'd0;
            primed     <= 1'b0;
        end else begin
            frame_stb <= close_pend;
            if (close_pend) begin
                cur        <= snap;
                overflow   <= snap_ovf;
                primed     <= 1'b1;
                stable_cnt <= stable_n;
                locked     <= (stable_n == STABLE_N);
            end
            if (pix_sat) begin
                locked     <= 1'b0;
                stable_cnt <= 4'd0;
            end
        end
    end

    assign h_total  = cur.h_total;
    assign h_active = cur.h_active;
    assign v_total  = cur.v_total;
    assign v_active = cur.v_active;
    assign hs_pol   = cur.hs_pol;
    assign vs_pol   = cur.vs_pol;

endmodule

// File: tb/tb_video_timing_meter.sv
// Bench for video_timing_meter: scaled VGA-shaped streams (40x20 total, 32x16
// active), expected frame reports queued as the bench drives each vs edge and
// compared when frame_stb appears.
module tb_video_timing_meter;

    localparam int HT = 40, DW = 32, HS0 = 34, HSW = 4;
    localparam int VT = 20, AL = 16, VS0 = 17;

    logic        clk_sys = 1'b0;
    logic        reset, ce_pix, hs, vs, de;
    logic [11:0] h_total, h_active;
    logic [10:0] v_total, v_active;
    logic        hs_pol, vs_pol, frame_stb, locked, overflow;

    video_timing_meter #(.HW(12), .VW(11), .STABLE_FRAMES(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .frame_stb(frame_stb), .locked(locked),
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit chk;
        int ht, ha, vt, va;
        bit hp, vp, lk, ov;
    } exp_t;

    typedef struct {
        bit inv;
        int ce_div, full_from, lock_at;
        int ht, ha, vt, va;
        bit hp, vp;
        int frames;
    } vec_t;

    exp_t sb_q[$];
    exp_t cur_exp, mon_e;
    int   checks = 0, errors = 0;
    int   stb_idx, full_from, lock_at, ce_div;
    bit   last_vs, prev_stb = 1'b0;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue an expected report whenever a vs rising edge is about to be driven
    task automatic drive(input logic h, input logic v, input logic d);
        exp_t e;
        if (v && !last_vs) begin
            stb_idx++;
            e     = cur_exp;
            e.chk = (stb_idx >= full_from);
            e.lk  = (stb_idx >= lock_at);
            sb_q.push_back(e);
        end
        last_vs = v;
        hs = h; vs = v; de = d; ce_pix = 1'b1;
        @(posedge clk_sys); #1;
        if (ce_div == 2) begin
            ce_pix = 1'b0;
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic gen_frame(input int ht, input int vt, input int al, input int dw,
                             input int hs0, input int hsw, input int vs0, input bit inv);
        bit ha, va;
        for (int y = 0; y < vt; y++)
            for (int x = 0; x < ht; x++) begin
                ha = (x >= hs0) && (x < hs0 + hsw);
                va = (y >= vs0) && (y < vs0 + 2);
                drive(inv ? ha : ~ha, inv ? va : ~va, (x < dw) && (y < al));
            end
    endtask

    task automatic do_reset();
        reset = 1'b1; ce_pix = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
        sb_q.delete();
        stb_idx = 0; last_vs = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_val("rst_h_total", h_total, 0);
        check_val("rst_v_total", v_total, 0);
        check_val("rst_hs_pol", hs_pol, 1);
        check_val("rst_vs_pol", vs_pol, 1);
        check_val("rst_locked", locked, 0);
        check_val("rst_stb", frame_stb, 0);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        ce_pix = 1'b0;
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Scoreboard side: compare each frame report, and check the strobe width
    always @(negedge clk_sys) begin
        if (frame_stb) begin
            check_val("stb_width", int'(prev_stb), 0);
            if (sb_q.size() == 0) begin
                check_val("unexpected_stb", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("locked", locked, mon_e.lk);
                check_val("overflow", overflow, mon_e.ov);
                if (mon_e.chk) begin
                    check_val("h_total", h_total, mon_e.ht);
                    check_val("h_active", h_active, mon_e.ha);
                    check_val("v_total", v_total, mon_e.vt);
                    check_val("v_active", v_active, mon_e.va);
                    check_val("hs_pol", hs_pol, mon_e.hp);
                    check_val("vs_pol", vs_pol, mon_e.vp);
                end
            end
        end
        prev_stb = frame_stb;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[3];
        // Active-low syncs start with a spurious coincident edge (reset samples are 0),
        // so the first full frame is report 3; active-high starts cleanly.
        tbl[0] = '{inv:0, ce_div:1, full_from:3, lock_at:7, ht:HT, ha:DW, vt:VT, va:AL, hp:0, vp:0, frames:6};
        tbl[1] = '{inv:1, ce_div:1, full_from:2, lock_at:6, ht:HT, ha:DW, vt:VT, va:AL, hp:1, vp:1, frames:6};
        tbl[2] = '{inv:0, ce_div:2, full_from:3, lock_at:7, ht:HT, ha:DW, vt:VT, va:AL, hp:0, vp:0, frames:6};

        for (int i = 0; i < 3; i++) begin
            ce_div = tbl[i].ce_div;
            do_reset();
            full_from = tbl[i].full_from;
            lock_at   = tbl[i].lock_at;
            cur_exp   = '{chk:1, ht:tbl[i].ht, ha:tbl[i].ha, vt:tbl[i].vt, va:tbl[i].va,
                          hp:tbl[i].hp, vp:tbl[i].vp, lk:0, ov:0};
            for (int f = 0; f < tbl[i].frames; f++)
                gen_frame(HT, VT, AL, DW, HS0, HSW, VS0, tbl[i].inv);
            idle(4);
            check_val("sb_drained", sb_q.size(), 0);
            check_val("stb_count", stb_idx, tbl[i].lock_at);
            check_val("locked_end", locked, 1);
        end

        // Lock, one frame of 41-pixel lines, recover, then lose hs/vs entirely
        ce_div = 1;
        do_reset();
        full_from = 3; lock_at = 7;
        cur_exp = '{chk:1, ht:HT, ha:DW, vt:VT, va:AL, hp:0, vp:0, lk:0, ov:0};
        for (int f = 0; f < 6; f++) gen_frame(HT, VT, AL, DW, HS0, HSW, VS0, 1'b0);
        check_val("pre_change_locked", locked, 1);
        cur_exp.ht = HT + 1;
        lock_at    = 13;
        gen_frame(HT + 1, VT, AL, DW, HS0, HSW, VS0, 1'b0);
        cur_exp.ht = HT;
        for (int f = 0; f < 5; f++) gen_frame(HT, VT, AL, DW, HS0, HSW, VS0, 1'b0);
        check_val("relocked", locked, 1);
        repeat (4000) drive(1'b1, 1'b1, 1'b0);
        check_val("hold_still_locked", locked, 1);
        repeat (100) drive(1'b1, 1'b1, 1'b0);
        check_val("los_locked", locked, 0);
        check_val("los_h_total", h_total, HT);
        check_val("los_v_total", v_total, VT);
        check_val("sb_drained_los", sb_q.size(), 0);

        // 5000-pixel lines saturate the pixel counter; then reset mid-frame
        do_reset();
        full_from = 99; lock_at = 99;
        cur_exp = '{chk:0, ht:0, ha:0, vt:0, va:0, hp:0, vp:0, lk:0, ov:1};
        gen_frame(5000, 3, 0, 640, 656, 96, 2, 1'b1);
        check_val("ovf_overflow", overflow, 1);
        check_val("ovf_h_total", h_total, 4095);
        check_val("ovf_locked", locked, 0);
        check_val("sb_drained_ovf", sb_q.size(), 0);
        for (int x = 0; x < 100; x++) drive(1'b0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_h_total", h_total, 0);
        check_val("midrst_h_active", h_active, 0);
        check_val("midrst_v_total", v_total, 0);
        check_val("midrst_v_active", v_active, 0);
        check_val("midrst_hs_pol", hs_pol, 1);
        check_val("midrst_vs_pol", vs_pol, 1);
        check_val("midrst_overflow", overflow, 0);
        check_val("midrst_locked", locked, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
